// File: rtl/l1_arbiter_if.sv
// l2_requester_interface: L1 requester to L2 bridge request/write-data/read-return bundle
// master drives requests and write data and acknowledges returns; slave flags full and returns reads
interface l2_requester_interface #(parameter int SUB_ID_W = 2);
  logic [29:0]         addr;
  logic [3:0]          be;
  logic                rnw;
  logic                is_amo;
  logic [4:0]          amo_type_or_burst_size;
  logic [SUB_ID_W-1:0] sub_id;
  logic                request_push;
  logic                request_full;
  logic [31:0]         wr_data;
  logic                wr_data_push;
  logic                data_full;
  logic [31:0]         rd_data;
  logic                rd_data_valid;
  logic [SUB_ID_W-1:0] rd_sub_id;
  logic                rd_data_ack;
  modport master (
    output addr, be, rnw, is_amo, amo_type_or_burst_size, sub_id, request_push, wr_data, wr_data_push, rd_data_ack,
    input  request_full, data_full, rd_data, rd_data_valid, rd_sub_id
  );
  modport slave (
    input  addr, be, rnw, is_amo, amo_type_or_burst_size, sub_id, request_push, wr_data, wr_data_push, rd_data_ack,
    output request_full, data_full, rd_data, rd_data_valid, rd_sub_id
  );
endinterface

// File: rtl/l1_arbiter.sv
// l1_arbiter: round-robin merge of instruction/data L1 requesters onto one L2 requester stream
// clk, rst (sync, active-low); port0/port1 slave requesters (sub_id MSB becomes the port tag);
// l2 master toward the bridge, read returns routed back by rd_sub_id MSB
module l1_arbiter_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp, r_rp;
  logic         w_push, w_pop;
  assign o_empty = r_wp == r_rp;
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
    end
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wp[AW-1:0]] <= i_din;
endmodule

module l1_arbiter #(
  parameter int REQ_DEPTH  = 4,
  parameter int DATA_DEPTH = 16,
  parameter int SUB_ID_W   = 2
) (
  input logic                  clk,
  input logic                  rst,
  l2_requester_interface.slave  port0,
  l2_requester_interface.slave  port1,
  l2_requester_interface.master l2
);
  // requester sub_id MSB is not stored: the port tag replaces it at grant
  localparam int RW = 40 + SUB_ID_W;
  typedef enum logic {IDLE, WRITE_DATA} state_t;
  state_t                r_state, w_state_nxt;
  logic                  r_last_grant, w_last_grant_nxt;
  logic                  r_data_port, w_data_port_nxt;
  logic [5:0]            r_word_cnt, w_word_cnt_nxt, w_words;
  logic [RW-1:0]         w_req_in [2];
  logic [RW-1:0]         w_req_head [2];
  logic [31:0]           w_dat_head [2];
  logic [1:0]            w_req_empty, w_req_full, w_dat_empty, w_dat_full, w_req_pop, w_dat_pop, w_req_valid;
  logic [RW-1:0]         w_head;
  logic [SUB_ID_W-2:0]   w_head_sid;
  logic [4:0]            w_head_bs;
  logic                  w_head_rnw, w_head_amo, w_gnt_port, w_grant, w_wr;
  logic [1:0]            r_rd_valid;
  logic [31:0]           r_rd_data;
  logic [SUB_ID_W-1:0]   r_rd_sub_id;
  assign w_req_in[0] = {port0.addr, port0.be, port0.rnw, port0.is_amo, port0.amo_type_or_burst_size, port0.sub_id[SUB_ID_W-2:0]};
  assign w_req_in[1] = {port1.addr, port1.be, port1.rnw, port1.is_amo, port1.amo_type_or_burst_size, port1.sub_id[SUB_ID_W-2:0]};
  l1_arbiter_fifo #(.W(RW), .DEPTH(REQ_DEPTH)) u_req0 (
    .clk(clk), .rst(rst), .i_push(port0.request_push), .i_pop(w_req_pop[0]), .i_din(w_req_in[0]),
    .o_dout(w_req_head[0]), .o_empty(w_req_empty[0]), .o_full(w_req_full[0])
  );
  l1_arbiter_fifo #(.W(RW), .DEPTH(REQ_DEPTH)) u_req1 (
    .clk(clk), .rst(rst), .i_push(port1.request_push), .i_pop(w_req_pop[1]), .i_din(w_req_in[1]),
    .o_dout(w_req_head[1]), .o_empty(w_req_empty[1]), .o_full(w_req_full[1])
  );
  l1_arbiter_fifo #(.W(32), .DEPTH(DATA_DEPTH)) u_dat0 (
    .clk(clk), .rst(rst), .i_push(port0.wr_data_push), .i_pop(w_dat_pop[0]), .i_din(port0.wr_data),
    .o_dout(w_dat_head[0]), .o_empty(w_dat_empty[0]), .o_full(w_dat_full[0])
  );
  l1_arbiter_fifo #(.W(32), .DEPTH(DATA_DEPTH)) u_dat1 (
    .clk(clk), .rst(rst), .i_push(port1.wr_data_push), .i_pop(w_dat_pop[1]), .i_din(port1.wr_data),
    .o_dout(w_dat_head[1]), .o_empty(w_dat_empty[1]), .o_full(w_dat_full[1])
  );
  assign port0.request_full = w_req_full[0];
  assign port1.request_full = w_req_full[1];
  assign port0.data_full    = w_dat_full[0];
  assign port1.data_full    = w_dat_full[1];
  // round robin: on a tie the port that did not win last time goes
  assign w_req_valid = ~w_req_empty;
  assign w_gnt_port  = &w_req_valid ? ~r_last_grant : w_req_valid[1];
  assign w_grant     = (r_state == IDLE) && |w_req_valid && !l2.request_full;
  assign w_wr        = (r_state == WRITE_DATA) && !w_dat_empty[r_data_port] && !l2.data_full;
  assign w_head      = w_req_head[w_gnt_port];
  assign {l2.addr, l2.be, w_head_rnw, w_head_amo, w_head_bs, w_head_sid} = w_head;
  assign l2.rnw                    = w_head_rnw;
  assign l2.is_amo                 = w_head_amo;
  assign l2.amo_type_or_burst_size = w_head_bs;
  assign l2.sub_id                 = {w_gnt_port, w_head_sid};
  assign l2.request_push           = w_grant;
  assign l2.wr_data_push           = w_wr;
  assign l2.wr_data                = w_dat_head[r_data_port];
  assign w_req_pop = w_grant ? (w_gnt_port ? 2'b10 : 2'b01) : 2'b00;
  assign w_dat_pop = w_wr ? (r_data_port ? 2'b10 : 2'b01) : 2'b00;
  assign w_words   = w_head_rnw ? 6'd0 : w_head_amo ? 6'd1 : {1'b0, w_head_bs} + 6'd1;
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_data_port_nxt  = r_data_port;
    w_word_cnt_nxt   = r_word_cnt;
    if (w_grant) begin
      w_last_grant_nxt = w_gnt_port;
      if (!w_head_rnw) begin
        w_state_nxt     = WRITE_DATA;
        w_word_cnt_nxt  = w_words;
        w_data_port_nxt = w_gnt_port;
      end
    end
    if (w_wr) begin
      w_word_cnt_nxt = r_word_cnt - 6'd1;
      w_state_nxt    = (r_word_cnt == 6'd1) ? IDLE : WRITE_DATA;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_data_port  <= 1'b0;
      r_word_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_data_port  <= w_data_port_nxt;
      r_word_cnt   <= w_word_cnt_nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_valid  <= '0;
      r_rd_data   <= '0;
      r_rd_sub_id <= '0;
    end else begin
      r_rd_valid  <= {l2.rd_data_valid & l2.rd_sub_id[SUB_ID_W-1], l2.rd_data_valid & ~l2.rd_sub_id[SUB_ID_W-1]};
      r_rd_data   <= l2.rd_data;
      r_rd_sub_id <= {1'b0, l2.rd_sub_id[SUB_ID_W-2:0]};
    end
  end
  assign port0.rd_data_valid = r_rd_valid[0];
  assign port1.rd_data_valid = r_rd_valid[1];
  assign port0.rd_data       = r_rd_data;
  assign port1.rd_data       = r_rd_data;
  assign port0.rd_sub_id     = r_rd_sub_id;
  assign port1.rd_sub_id     = r_rd_sub_id;
  assign l2.rd_data_ack      = 1'b1;
endmodule

// File: tb/tb_l1_arbiter.sv
// tb_l1_arbiter: queue-based model check of l1_arbiter plus directed literal expectations
module tb_l1_arbiter;
  localparam int REQ_DEPTH  = 4;
  localparam int DATA_DEPTH = 16;
  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
    logic        rnw;
    logic        amo;
    logic [4:0]  bs;
    logic [1:0]  sid;
  } req_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  l2_requester_interface #(.SUB_ID_W(2)) p0 ();
  l2_requester_interface #(.SUB_ID_W(2)) p1 ();
  l2_requester_interface #(.SUB_ID_W(2)) l2i ();
  l1_arbiter #(.REQ_DEPTH(REQ_DEPTH), .DATA_DEPTH(DATA_DEPTH), .SUB_ID_W(2)) dut (
    .clk(clk), .rst(rst), .port0(p0), .port1(p1), .l2(l2i)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // model state: pending requests/data per port, words still owed by the open write
  req_t        rq [2][$];
  logic [31:0] dq [2][$];
  int          burst = 0;
  int          bport = 0;
  int          last  = 1;
  logic [1:0]  mv = 2'b00;
  logic [31:0] md = '0;
  logic [1:0]  ms = '0;
  int          gl_cyc [$];
  logic [1:0]  gl_sid [$];
  logic        gl_rnw [$];
  logic [29:0] gl_addr [$];
  logic [31:0] dl_dat [$];
  int          dl_cyc [$];
  req_t        mh;
  req_t        in_r [2];
  int          mg, s_rq [2], s_dq [2];
  logic        mep, mew;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask
  always @(negedge clk) if (cyc > 0) begin
    s_rq[0] = rq[0].size(); s_rq[1] = rq[1].size();
    s_dq[0] = dq[0].size(); s_dq[1] = dq[1].size();
    mg  = (s_rq[0] > 0 && s_rq[1] > 0) ? 1 - last : (s_rq[1] > 0 ? 1 : 0);
    mep = burst == 0 && (s_rq[0] + s_rq[1]) > 0 && !l2i.request_full;
    mew = burst > 0 && s_dq[bport] > 0 && !l2i.data_full;
    chk("req_push", l2i.request_push, mep);
    if (mep) begin
      mh = rq[mg][0];
      chk("req_payload", {l2i.addr, l2i.be, l2i.rnw, l2i.is_amo, l2i.amo_type_or_burst_size, l2i.sub_id},
          {mh.addr, mh.be, mh.rnw, mh.amo, mh.bs, mg == 1, mh.sid[0]});
    end
    chk("wr_push", l2i.wr_data_push, mew);
    if (mew) chk("wr_data", l2i.wr_data, dq[bport][0]);
    chk("fulls", {p0.request_full, p1.request_full, p0.data_full, p1.data_full},
        {s_rq[0] == REQ_DEPTH, s_rq[1] == REQ_DEPTH, s_dq[0] == DATA_DEPTH, s_dq[1] == DATA_DEPTH});
    chk("rd_valid", {p1.rd_data_valid, p0.rd_data_valid}, mv);
    if (mv[0]) chk("p0_rd", {p0.rd_data, p0.rd_sub_id}, {md, ms});
    if (mv[1]) chk("p1_rd", {p1.rd_data, p1.rd_sub_id}, {md, ms});
    chk("rd_ack", l2i.rd_data_ack, 1'b1);
    chk("push_while_full", (p0.request_push & p0.request_full) | (p1.request_push & p1.request_full) |
        (p0.wr_data_push & p0.data_full) | (p1.wr_data_push & p1.data_full), 1'b0);
    if (rst) begin
      if (l2i.request_push) begin
        gl_cyc.push_back(cyc); gl_sid.push_back(l2i.sub_id); gl_rnw.push_back(l2i.rnw); gl_addr.push_back(l2i.addr);
      end
      if (l2i.wr_data_push) begin
        dl_cyc.push_back(cyc); dl_dat.push_back(l2i.wr_data);
      end
    end
    in_r[0] = {p0.addr, p0.be, p0.rnw, p0.is_amo, p0.amo_type_or_burst_size, p0.sub_id};
    in_r[1] = {p1.addr, p1.be, p1.rnw, p1.is_amo, p1.amo_type_or_burst_size, p1.sub_id};
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        rq[p].delete(); dq[p].delete();
      end
      burst = 0; bport = 0; last = 1;
      mv = 2'b00; md = '0; ms = '0;
    end else begin
      if (mep) begin
        void'(rq[mg].pop_front());
        last = mg;
        if (!mh.rnw) begin
          burst = mh.amo ? 1 : int'(mh.bs) + 1;
          bport = mg;
        end
      end else if (mew) begin
        void'(dq[bport].pop_front());
        burst--;
      end
      if (p0.request_push && s_rq[0] < REQ_DEPTH) rq[0].push_back(in_r[0]);
      if (p1.request_push && s_rq[1] < REQ_DEPTH) rq[1].push_back(in_r[1]);
      if (p0.wr_data_push && s_dq[0] < DATA_DEPTH) dq[0].push_back(p0.wr_data);
      if (p1.wr_data_push && s_dq[1] < DATA_DEPTH) dq[1].push_back(p1.wr_data);
      mv = {l2i.rd_data_valid & l2i.rd_sub_id[1], l2i.rd_data_valid & ~l2i.rd_sub_id[1]};
      md = l2i.rd_data;
      ms = {1'b0, l2i.rd_sub_id[0]};
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic clr();
    p0.request_push = 0; p1.request_push = 0; p0.wr_data_push = 0; p1.wr_data_push = 0;
  endtask
  task automatic clear_logs();
    gl_cyc.delete(); gl_sid.delete(); gl_rnw.delete(); gl_addr.delete(); dl_dat.delete(); dl_cyc.delete();
  endtask
  task automatic set_req(input int p, input logic rnw, input logic amo, input logic [4:0] bs,
                         input logic [29:0] a, input logic [1:0] sid);
    if (p == 0) begin
      p0.addr = a; p0.be = a[3:0]; p0.rnw = rnw; p0.is_amo = amo;
      p0.amo_type_or_burst_size = bs; p0.sub_id = sid; p0.request_push = 1;
    end else begin
      p1.addr = a; p1.be = a[3:0]; p1.rnw = rnw; p1.is_amo = amo;
      p1.amo_type_or_burst_size = bs; p1.sub_id = sid; p1.request_push = 1;
    end
  endtask
  task automatic set_wd(input int p, input logic [31:0] d);
    if (p == 0) begin p0.wr_data = d; p0.wr_data_push = 1; end
    else begin p1.wr_data = d; p1.wr_data_push = 1; end
  endtask
  initial begin
    int rel;
    p0.addr = '0; p0.be = '0; p0.rnw = 0; p0.is_amo = 0; p0.amo_type_or_burst_size = '0; p0.sub_id = '0;
    p1.addr = '0; p1.be = '0; p1.rnw = 0; p1.is_amo = 0; p1.amo_type_or_burst_size = '0; p1.sub_id = '0;
    p0.wr_data = '0; p1.wr_data = '0; p0.rd_data_ack = 1; p1.rd_data_ack = 1;
    clr();
    l2i.request_full = 0; l2i.data_full = 0; l2i.rd_data_valid = 0; l2i.rd_data = '0; l2i.rd_sub_id = '0;
    idle(3);
    chk("rst_pushes", {l2i.request_push, l2i.wr_data_push}, 2'b00);
    chk("rst_fulls", {p0.request_full, p1.request_full, p0.data_full, p1.data_full}, 4'b0000);
    chk("rst_valids", {p0.rd_data_valid, p1.rd_data_valid}, 2'b00);
    rst = 1;
    idle(2);
    // tie right after reset: port0 first, its sub_id MSB replaced by the tag
    set_req(0, 1, 0, 0, 30'h100, 2'b11);
    set_req(1, 1, 0, 0, 30'h200, 2'b00);
    tick(); clr();
    @(negedge clk);
    chk("tie_first", {l2i.request_push, l2i.sub_id, l2i.addr}, {1'b1, 2'b01, 30'h100});
    @(negedge clk);
    chk("tie_second", {l2i.request_push, l2i.sub_id, l2i.addr}, {1'b1, 2'b10, 30'h200});
    tick();
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1, 0, 0, 30'h110 + 30'(i), 2'b00);
      set_req(1, 1, 0, 0, 30'h210 + 30'(i), 2'b01);
      tick(); clr();
    end
    idle(6);
    chk("alt_count", gl_cyc.size(), 6);
    for (int i = 0; i < gl_cyc.size(); i++) begin
      chk("alt_port", gl_sid[i][1], i % 2);
      chk("alt_back_to_back", gl_cyc[i] - gl_cyc[0], i);
    end
    // write burst from port1 with a port0 read arriving behind it
    clear_logs();
    set_req(1, 0, 0, 5'd3, 30'h300, 2'b00); set_wd(1, 32'hA0);
    tick(); clr();
    set_req(0, 1, 0, 0, 30'h400, 2'b00); set_wd(1, 32'hA1);
    tick(); clr();
    set_wd(1, 32'hA2); tick(); clr();
    set_wd(1, 32'hA3); tick(); clr();
    idle(4);
    chk("wb_grants", gl_cyc.size(), 2);
    chk("wb_words", dl_dat.size(), 4);
    if (gl_cyc.size() == 2 && dl_dat.size() == 4) begin
      chk("wb_first_req", {gl_sid[0], gl_rnw[0], gl_addr[0]}, {2'b10, 1'b0, 30'h300});
      for (int i = 0; i < 4; i++) begin
        chk("wb_data", dl_dat[i], 32'hA0 + i);
        chk("wb_data_cycle", dl_cyc[i] - gl_cyc[0], i + 1);
      end
      chk("wb_read_after", gl_cyc[1] - dl_cyc[3], 1);
      chk("wb_read_req", {gl_sid[1][1], gl_rnw[1], gl_addr[1]}, {1'b0, 1'b1, 30'h400});
    end
    // request backpressure: last grant was port0, so port1 wins once released
    clear_logs();
    l2i.request_full = 1;
    set_req(0, 1, 0, 0, 30'h500, 2'b00);
    set_req(1, 1, 0, 0, 30'h600, 2'b00);
    tick(); clr();
    idle(4);
    chk("bp_no_grant", gl_cyc.size(), 0);
    l2i.request_full = 0;
    rel = cyc;
    idle(3);
    chk("bp_grants", gl_cyc.size(), 2);
    if (gl_cyc.size() == 2) begin
      chk("bp_first", {gl_sid[0][1], gl_addr[0]}, {1'b1, 30'h600});
      chk("bp_first_cycle", gl_cyc[0], rel);
      chk("bp_second", {gl_sid[1][1], gl_addr[1]}, {1'b0, 30'h500});
    end
    // data backpressure toggling every cycle during a 4-word write
    clear_logs();
    set_req(0, 0, 0, 5'd3, 30'h700, 2'b01); set_wd(0, 32'hB0); l2i.data_full = 0;
    tick(); clr();
    for (int i = 1; i < 12; i++) begin
      if (i < 4) set_wd(0, 32'hB0 + i);
      l2i.data_full = i[0];
      tick(); clr();
    end
    l2i.data_full = 0;
    idle(2);
    chk("df_words", dl_dat.size(), 4);
    if (dl_dat.size() == 4 && gl_cyc.size() == 1) begin
      for (int i = 0; i < 4; i++) begin
        chk("df_data", dl_dat[i], 32'hB0 + i);
        chk("df_cycle", dl_cyc[i] - gl_cyc[0], 1 + 2 * i);
      end
    end
    // AMO write carries a single word regardless of the type field
    clear_logs();
    set_req(1, 0, 1, 5'd7, 30'h7A0, 2'b00); set_wd(1, 32'hC0);
    tick(); clr();
    set_req(1, 1, 0, 0, 30'h7B0, 2'b01);
    tick(); clr();
    idle(4);
    chk("amo_words", dl_dat.size(), 1);
    chk("amo_grants", gl_cyc.size(), 2);
    if (dl_dat.size() == 1 && gl_cyc.size() == 2) chk("amo_read_after", gl_cyc[1] - dl_cyc[0], 1);
    // return routing
    l2i.rd_data_valid = 1; l2i.rd_sub_id = 2'b10; l2i.rd_data = 32'h1234;
    tick();
    l2i.rd_data_valid = 0;
    @(negedge clk);
    chk("ret1", {p1.rd_data_valid, p1.rd_data, p1.rd_sub_id, p0.rd_data_valid}, {1'b1, 32'h1234, 2'b00, 1'b0});
    tick();
    l2i.rd_data_valid = 1; l2i.rd_sub_id = 2'b01; l2i.rd_data = 32'h55AA;
    tick();
    l2i.rd_data_valid = 0;
    @(negedge clk);
    chk("ret0", {p0.rd_data_valid, p0.rd_data, p0.rd_sub_id, p1.rd_data_valid}, {1'b1, 32'h55AA, 2'b01, 1'b0});
    tick();
    // reset in the middle of a 4-word write
    clear_logs();
    for (int k = 0; k < 20 && dl_dat.size() < 2; k++) begin
      if (k == 0) set_req(0, 0, 0, 5'd3, 30'h800, 2'b00);
      if (k < 4) set_wd(0, 32'hD0 + k);
      tick(); clr();
    end
    chk("mid_words_before", dl_dat.size(), 2);
    rst = 0;
    idle(2);
    rst = 1;
    idle(6);
    chk("mid_no_more_words", dl_dat.size(), 2);
    chk("mid_no_more_grants", gl_cyc.size(), 1);
    chk("mid_fulls", {p0.request_full, p1.request_full, p0.data_full, p1.data_full}, 4'b0000);
    clear_logs();
    set_req(0, 0, 0, 5'd0, 30'h900, 2'b00); set_wd(0, 32'hE0);
    tick(); clr();
    idle(4);
    chk("post_rst_grants", gl_cyc.size(), 1);
    if (gl_cyc.size() == 1) chk("post_rst_req", {gl_sid[0], gl_rnw[0], gl_addr[0]}, {2'b00, 1'b0, 30'h900});
    chk("post_rst_words", dl_dat.size(), 1);
    if (dl_dat.size() == 1) chk("post_rst_data", dl_dat[0], 32'hE0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
